lcd_scheduler: RTL and testbench
================================

LCD_SCHEDULER -- requirements
Module: lcd_scheduler

Interface
REQ-001 Parameter T_PWRUP, 2000000, power-up wait in clk cycles (40 ms at 50 MHz).
REQ-002 Parameter T_AS, 3, RS/data setup cycles before lcd_e rises.
REQ-003 Parameter T_PW, 25, lcd_e high cycles.
REQ-004 Parameter T_H, 3, hold cycles after lcd_e falls, with RS/data stable.
REQ-005 Parameter T_SHORT, 2500, post-transfer wait for ordinary commands and data.
REQ-006 Parameter T_LONG, 82000, post-transfer wait for clear/home commands.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  sole clock; all state on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 reqN_valid  in  1  (N=0,1) requester N has a byte pending.
REQ-011 reqN_rs  in  1  0 = command byte, 1 = character data.
REQ-012 reqN_data  in  8  byte to write.
REQ-013 reqN_ready  out  1  single-cycle accept strobe; transfer occurs when valid&ready at an edge.
REQ-014 lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon  out  1 each  HD44780 control pins.
REQ-015 data_lcd  out  8  LCD data bus.
REQ-016 init_done  out  1  high once the init sequence completes.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 FSM states: PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-019 PWRUP counts T_PWRUP cycles, then goes to INIT_LOAD.
REQ-020 INIT_LOAD issues 0x38, 0x0C, 0x06, 0x01 in order with rs=0, each through SETUP/PULSE/HOLD/WAIT.
REQ-021 init_done rises on the cycle IDLE is first entered after the fourth init byte's WAIT, and stays high until reset.
REQ-022 reqN_ready stays 0 until init_done=1.
REQ-023 In IDLE with init_done=1 and any valid: assert ready to exactly one requester for one cycle, latch its rs/data, and go to SETUP.
REQ-024 Arbitration is round-robin: with both valid, grant the requester not granted last; last-grant resets to 1, so req0 wins the first tie.
REQ-025 A single valid requester is granted regardless of last-grant.
REQ-026 Requesters hold rs/data stable while valid; valid may drop before ready only by withdrawing, which causes no transfer.
REQ-027 SETUP: lcd_rs/data_lcd driven from the latch on the entry edge; lcd_e=0 for T_AS cycles.
REQ-028 PULSE: lcd_e=1 for exactly T_PW cycles.
REQ-029 HOLD: lcd_e=0 with RS/data unchanged for T_H cycles.
REQ-030 WAIT duration is T_LONG when rs=0 and data[7:1]=7'b0000000 (0x01 clear, 0x02/0x03 home); otherwise T_SHORT.
REQ-031 WAIT then returns to IDLE, or to INIT_LOAD while init is incomplete; no request is accepted before IDLE.
REQ-032 Back-to-back transfers are separated by at least T_AS+T_PW+T_H+T_SHORT cycles.
REQ-033 lcd_rw is constant 0; lcd_on and lcd_blon are constant 1.
REQ-034 A single down-counter is sized to the maximum parameter value; phase ends when the counter reaches 0.

Reset
REQ-035 Reset values: state=PWRUP, lcd_e=0, lcd_rs=0, data_lcd=0x00, lcd_rw=0, lcd_on=1, lcd_blon=1, reqN_ready=0, init_done=0, busy=1, last-grant=1, init index=0.
REQ-036 Reset asserted mid-transfer forces lcd_e=0 on the next edge, drops the latched byte, and restarts PWRUP and the full init sequence.

Structure
REQ-037 Shared package lcd_pkg holds the state enum, the init command constants (CMD_FUNCSET=0x38, CMD_DISPON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_LINE2=0xC0), and the long-command predicate.
REQ-038 Sub-module lcd_rr_arb implements the 2-way round-robin grant with last-grant state.

Verification (T_PWRUP=20, T_AS=2, T_PW=4, T_H=2, T_SHORT=10, T_LONG=40)
REQ-039 Release reset, no requests -> data_lcd sequence 0x38, 0x0C, 0x06, 0x01, each with 4-cycle lcd_e pulse and rs=0; waits after each are 10, 10, 10, 40 cycles; init_done=1 afterwards.
REQ-040 After init, req0 = {rs=1, 0x4D} -> one ready pulse; lcd_rs=1, data 0x4D; lcd_e rises 2 cycles after latch, high 4, busy for 18 cycles total.
REQ-041 req0 and req1 both valid continuously -> grants alternate 0,1,0,1; no requester is starved.
REQ-042 req1 = {rs=0, 0x01} -> 40-cycle WAIT; req1 = {rs=0, 0xC0} -> 10-cycle WAIT.
REQ-043 rst pulsed during PULSE of a data write -> lcd_e=0 the next cycle, init_done=0, init sequence replays from 0x38.
REQ-044 Requests asserted before init_done -> ready stays 0 until init completes, then is granted in round-robin order.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 write scheduler.
//   lcd_state_e  - scheduler FSM states
//   lcd_req_t    - latched byte {rs, data}
//   CMD_*        - controller command bytes used by the init sequence
//   init_cmd()   - init byte by index, is_long_cmd() - clear/home predicate
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_LOAD,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  localparam logic [7:0] CMD_FUNCSET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISPON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY   = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_LINE2   = 8'hC0;  // DDRAM address 0x40

  localparam int unsigned INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    c = CMD_FUNCSET;
    case (idx)
      2'd0:    c = CMD_FUNCSET;
      2'd1:    c = CMD_DISPON;
      2'd2:    c = CMD_ENTRY;
      default: c = CMD_CLEAR;
    endcase
    return c;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  function automatic logic is_long_cmd(input lcd_req_t r);
    return (!r.rs) && (r.data[7:1] == 7'b0000000);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// lcd_rr_arb: 2-way round-robin grant for the LCD scheduler.
//   clk/rst   - clock, synchronous active-high reset
//   valid_i   - per-requester pending flags
//   accept_i  - a grant is being consumed this cycle
//   gnt_o     - one-hot grant (combinational)
// last_q records which requester was granted last; it resets to 1 so that
// requester 0 wins the first tie.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  assign last_d = (accept_i && (|valid_i)) ? gnt_o[1] : last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/lcd_scheduler.sv
// lcd_scheduler: HD44780 8-bit write scheduler with power-up init and two
// round-robin requesters.
//   clk, rst                 - clock, synchronous active-high reset
//   reqN_valid/rs/data       - requester N byte (N=0,1)
//   reqN_ready               - one-cycle accept strobe (valid&ready = transfer)
//   lcd_e, lcd_rs, data_lcd  - controller bus; lcd_rw/lcd_on/lcd_blon constant
//   init_done                - init sequence finished
//   busy                     - FSM not in IDLE
// Every timed phase loads one shared down-counter with (duration-1) on entry
// and leaves when it reaches zero, so a phase of N lasts exactly N cycles.
module lcd_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 2000000,
  parameter int unsigned T_AS    = 3,
  parameter int unsigned T_PW    = 25,
  parameter int unsigned T_H     = 3,
  parameter int unsigned T_SHORT = 2500,
  parameter int unsigned T_LONG  = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic [7:0] data_lcd,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_PWRUP, T_LONG), max_u(T_SHORT, T_PW)),
                                        max_u(T_AS, T_H));
  localparam int CW = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] LD_AS    = CW'(T_AS - 1);
  localparam logic [CW-1:0] LD_PW    = CW'(T_PW - 1);
  localparam logic [CW-1:0] LD_H     = CW'(T_H - 1);
  localparam logic [CW-1:0] LD_SHORT = CW'(T_SHORT - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG - 1);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  lcd_req_t      xfer_q, xfer_d;
  logic [2:0]    idx_q, idx_d;
  logic          done_q, done_d;

  logic [1:0]    req_valid, gnt;
  logic          accept, cnt_zero;
  lcd_req_t      sel_req;

  assign req_valid = {req1_valid, req0_valid};
  assign accept    = (state_q == IDLE) && done_q && (|req_valid);
  assign cnt_zero  = (cnt_q == '0);
  assign sel_req   = gnt[1] ? {req1_rs, req1_data} : {req0_rs, req0_data};

  lcd_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (req_valid),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer_d  = xfer_q;
    idx_d   = idx_q;
    done_d  = done_q;
    unique case (state_q)
      PWRUP: begin
        if (cnt_zero) state_d = INIT_LOAD;
        else          cnt_d   = cnt_q - 1'b1;
      end
      INIT_LOAD: begin
        xfer_d.rs   = 1'b0;
        xfer_d.data = init_cmd(idx_q[1:0]);
        idx_d       = idx_q + 3'd1;
        state_d     = SETUP;
        cnt_d       = LD_AS;
      end
      IDLE: begin
        if (accept) begin
          xfer_d  = sel_req;
          state_d = SETUP;
          cnt_d   = LD_AS;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d = PULSE;
          cnt_d   = LD_PW;
        end else cnt_d = cnt_q - 1'b1;
      end
      PULSE: begin
        if (cnt_zero) begin
          state_d = HOLD;
          cnt_d   = LD_H;
        end else cnt_d = cnt_q - 1'b1;
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = WAIT;
          cnt_d   = is_long_cmd(xfer_q) ? LD_LONG : LD_SHORT;
        end else cnt_d = cnt_q - 1'b1;
      end
      WAIT: begin
        if (cnt_zero) begin
          // idx_q has already advanced past the last init byte when init is done
          if (idx_q == 3'(INIT_LEN)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = INIT_LOAD;
          end
        end else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = PWRUP;
        cnt_d   = LD_PWRUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWRUP;
      cnt_q   <= LD_PWRUP;
      xfer_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign req0_ready = accept & gnt[0];
  assign req1_ready = accept & gnt[1];

  assign lcd_e     = (state_q == PULSE);
  assign lcd_rs    = xfer_q.rs;
  assign data_lcd  = xfer_q.data;
  assign lcd_rw    = 1'b0;
  assign lcd_on    = 1'b1;
  assign lcd_blon  = 1'b1;
  assign init_done = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_scheduler.sv
// Directed bench for lcd_scheduler with shortened timing parameters.
module tb_lcd_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_rs = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon;
  logic [7:0] data_lcd;
  logic       init_done, busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lcd_scheduler #(
    .T_PWRUP(20), .T_AS(2), .T_PW(4), .T_H(2), .T_SHORT(10), .T_LONG(40)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_on     (lcd_on),
    .lcd_blon   (lcd_blon),
    .data_lcd   (data_lcd),
    .init_done  (init_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // Called at the negedge where rst has just been released. Checks the four
  // init bytes, pulse widths, gaps and the init_done rise. Expected gaps:
  // first rise: 19 PWRUP + 1 INIT_LOAD + 2 SETUP = 22 low samples;
  // between bytes: 2 HOLD + 10 WAIT + 1 INIT_LOAD + 2 SETUP = 15;
  // after 0x01: 2 HOLD + 40 WAIT = 42 samples before init_done.
  task automatic init_seq(input string tag);
    logic [7:0] exp_b [4];
    int gap, hi, expg, bad_rdy, bad_hold;
    exp_b[0] = 8'h38; exp_b[1] = 8'h0C; exp_b[2] = 8'h06; exp_b[3] = 8'h01;
    bad_rdy = 0; bad_hold = 0; gap = 0;
    for (int b = 0; b < 4; b++) begin
      do begin
        @(negedge clk);
        if ((req0_ready | req1_ready) && !init_done) bad_rdy++;
        if (lcd_e !== 1'b1) gap++;
      end while (lcd_e !== 1'b1 && gap < 500);
      expg = (b == 0) ? 22 : 15;
      total_cnt++;
      if (gap !== expg) $display("FAIL %s_gap byte%0d: got %0d want %0d", tag, b, gap, expg);
      else pass_cnt++;
      total_cnt++;
      if (data_lcd !== exp_b[b] || lcd_rs !== 1'b0)
        $display("FAIL %s_byte%0d: got rs=%b data=%h want rs=0 data=%h", tag, b, lcd_rs, data_lcd, exp_b[b]);
      else pass_cnt++;
      hi = 1;
      do begin
        @(negedge clk);
        if ((req0_ready | req1_ready) && !init_done) bad_rdy++;
        if (lcd_e === 1'b1) hi++;
      end while (lcd_e === 1'b1 && hi < 100);
      total_cnt++;
      if (hi !== 4) $display("FAIL %s_pw byte%0d: got %0d want 4", tag, b, hi);
      else pass_cnt++;
      if (data_lcd !== exp_b[b] || lcd_rs !== 1'b0) bad_hold++;
      gap = 1;
    end
    while (init_done !== 1'b1 && gap < 500) begin
      @(negedge clk);
      if ((req0_ready | req1_ready) && !init_done) bad_rdy++;
      if (init_done !== 1'b1) gap++;
    end
    total_cnt++;
    if (gap !== 42) $display("FAIL %s_clear_wait: got %0d want 42", tag, gap);
    else pass_cnt++;
    total_cnt++;
    if (init_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_done: got init_done=%b busy=%b want 1 0", tag, init_done, busy);
    else pass_cnt++;
    total_cnt++;
    if (bad_rdy !== 0) $display("FAIL %s_early_ready: got %0d want 0", tag, bad_rdy);
    else pass_cnt++;
    total_cnt++;
    if (bad_hold !== 0) $display("FAIL %s_hold_data: got %0d want 0", tag, bad_hold);
    else pass_cnt++;
  endtask

  // Called at a negedge with the DUT in IDLE; issues one byte from requester
  // `who` and measures setup, pulse width and total busy time.
  task automatic xfer(input int who, input logic rs, input logic [7:0] d,
                      input int exp_busy, input string tag);
    int lo, hi, bsy, bad;
    logic [1:0] exp_r;
    exp_r = (who == 0) ? 2'b01 : 2'b10;
    if (who == 0) begin req0_valid = 1'b1; req0_rs = rs; req0_data = d; end
    else          begin req1_valid = 1'b1; req1_rs = rs; req1_data = d; end
    #1;
    total_cnt++;
    if ({req1_ready, req0_ready} !== exp_r)
      $display("FAIL %s_ready: got %b want %b", tag, {req1_ready, req0_ready}, exp_r);
    else pass_cnt++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    lo = 0; hi = 0; bsy = 0; bad = 0;
    while (busy === 1'b1 && bsy < 500) begin
      bsy++;
      if (lcd_e === 1'b1) hi++;
      else if (hi == 0) lo++;
      if (lcd_rs !== rs || data_lcd !== d || req0_ready || req1_ready) bad++;
      @(negedge clk);
    end
    total_cnt++;
    if (lo !== 2) $display("FAIL %s_setup: got %0d want 2", tag, lo); else pass_cnt++;
    total_cnt++;
    if (hi !== 4) $display("FAIL %s_pw: got %0d want 4", tag, hi); else pass_cnt++;
    total_cnt++;
    if (bsy !== exp_busy) $display("FAIL %s_busy: got %0d want %0d", tag, bsy, exp_busy);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL %s_bus_stable: got %0d bad samples want 0", tag, bad);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon, req0_ready, req1_ready, init_done, busy} !== 9'b000110001)
      $display("FAIL reset_ctrl: got %b want 000110001",
               {lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_blon, req0_ready, req1_ready, init_done, busy});
    else pass_cnt++;
    total_cnt++;
    if (data_lcd !== 8'h00) $display("FAIL reset_data: got %h want 00", data_lcd); else pass_cnt++;
    rst = 1'b0;
    init_seq("init");
  endtask

  // 2 SETUP + 4 PULSE + 2 HOLD + 10 WAIT = 18 busy cycles
  task automatic test_single();
    xfer(0, 1'b1, 8'h4D, 18, "single");
  endtask

  // clear: 8 + 40 = 48; line-2 address: 8 + 10 = 18
  task automatic test_long_short();
    xfer(1, 1'b0, 8'h01, 48, "clear");
    xfer(1, 1'b0, 8'hC0, 18, "line2");
  endtask

  task automatic test_withdraw();
    int bad;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h77;
    #1;
    total_cnt++;
    if (req0_ready !== 1'b1) $display("FAIL withdraw_ready: got %b want 1", req0_ready);
    else pass_cnt++;
    #2 req0_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || lcd_e !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL withdraw_no_xfer: got %0d busy samples want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] seq;
    logic [1:0] g;
    int cyc, bad_data;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h42;
    seq = '0; bad_data = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!(req0_ready | req1_ready) && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      g = {req1_ready, req0_ready};
      seq = {seq[5:0], g};
      @(negedge clk);
      if (data_lcd !== ((g == 2'b01) ? 8'h41 : 8'h42)) bad_data++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total_cnt++;
    if (seq !== 8'b01_10_01_10) $display("FAIL rr_order: got %b want 01100110", seq);
    else pass_cnt++;
    total_cnt++;
    if (bad_data !== 0) $display("FAIL rr_data: got %0d wrong bytes want 0", bad_data);
    else pass_cnt++;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset_mid();
    int cyc;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
    @(negedge clk);
    req0_valid = 1'b0;
    cyc = 0;
    while (lcd_e !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    total_cnt++;
    if (lcd_e !== 1'b1) $display("FAIL mid_pulse_reached: got lcd_e=%b want 1", lcd_e);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (lcd_e !== 1'b0) $display("FAIL mid_rst_e: got %b want 0", lcd_e); else pass_cnt++;
    total_cnt++;
    if (init_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL mid_rst_flags: got init_done=%b busy=%b want 0 1", init_done, busy);
    else pass_cnt++;
    total_cnt++;
    if ({lcd_rs, data_lcd} !== 9'h000) $display("FAIL mid_rst_latch: got %h want 000", {lcd_rs, data_lcd});
    else pass_cnt++;
    // both requesters wait across the whole re-init
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h61;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h62;
    rst = 1'b0;
    init_seq("reinit");
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL pend_first_grant: got %b want 01", {req1_ready, req0_ready});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (data_lcd !== 8'h61) $display("FAIL pend_first_data: got %h want 61", data_lcd); else pass_cnt++;
    cyc = 0;
    while (!(req0_ready | req1_ready) && cyc < 100) begin @(negedge clk); cyc++; end
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b10)
      $display("FAIL pend_second_grant: got %b want 10", {req1_ready, req0_ready});
    else pass_cnt++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    total_cnt++;
    if (data_lcd !== 8'h62) $display("FAIL pend_second_data: got %h want 62", data_lcd); else pass_cnt++;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin @(negedge clk); cyc++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_long_short();
    test_withdraw();
    test_round_robin();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
